// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: main-pipeline writes win every slot, long-latency results queue and drain in idle slots.
// Optional macro WB_PASSTHRU_EN: an lu result that finds the queue empty and the slot free goes straight to the output register.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        pipe_wen,
    input  logic [ADDR_W-1:0]           pipe_waddr,
    input  logic [DATA_W-1:0]           pipe_wdata,
    input  logic                        lu_valid,
    input  logic [ADDR_W-1:0]           lu_waddr,
    input  logic [DATA_W-1:0]           lu_wdata,
    output logic                        lu_ready,
    output logic                        w_en,
    output logic [ADDR_W-1:0]           w_addr,
    output logic [DATA_W-1:0]           w_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic [ADDR_W-1:0]           q_addr,
    output logic                        q_pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ent_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] ent_data [FIFO_DEPTH];
    logic              ent_live [FIFO_DEPTH];
    logic [PW-1:0]     offs     [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] occupied;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic pipe_sel;
    logic pop;
    logic push;
    logic passthru;

    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign lu_ready   = resetn && !full;
    assign fifo_count = count;

    // A pipe write to r0 is not a write, so it leaves the slot to the queue.
    assign pipe_sel = pipe_wen && (pipe_waddr != '0);
    assign pop      = !pipe_sel && !empty;

`ifdef WB_PASSTHRU_EN
    assign passthru = !pipe_sel && empty && lu_valid && (lu_waddr != '0);
`else
    assign passthru = 1'b0;
`endif

    // Results for r0, or overwritten by a younger same-cycle pipe write, are accepted but never stored.
    assign push = lu_valid && lu_ready && (lu_waddr != '0)
                  && !(pipe_sel && (pipe_waddr == lu_waddr)) && !passthru;

    // An entry is occupied when its distance from the head is below the fill count.
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_occ
        assign offs[g]     = PW'(g) - rd_ptr;
        assign occupied[g] = ({1'b0, offs[g]} < count);
    end

    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (occupied[i] && ent_live[i] && (ent_addr[i] == q_addr) && (q_addr != '0))
                q_pending = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_live[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                ent_live[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            // Pipe writes are younger than anything queued, so matching queued entries become dead slots.
            if (pipe_sel) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (ent_addr[i] == pipe_waddr)
                        ent_live[i] <= 1'b0;
                end
            end
            if (push) begin
                ent_addr[wr_ptr] <= lu_waddr;
                ent_data[wr_ptr] <= lu_wdata;
                ent_live[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (pipe_sel) begin
                w_en   <= 1'b1;
                w_addr <= pipe_waddr;
                w_data <= pipe_wdata;
            end else if (passthru) begin
                w_en   <= 1'b1;
                w_addr <= lu_waddr;
                w_data <= lu_wdata;
            end else if (pop) begin
                w_en   <= ent_live[rd_ptr];
                w_addr <= ent_addr[rd_ptr];
                w_data <= ent_data[rd_ptr];
            end else begin
                w_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of per-cycle vectors plus hand-written reset and passthrough sequences.
// Expectations in the passthrough sequence follow WB_PASSTHRU_EN.
module tb_wb_arbiter;

    logic        clk;
    logic        resetn;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [2:0]  fifo_count;
    logic [4:0]  q_addr;
    logic        q_pending;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  qa;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_qp;
    } vec_t;

    vec_t vecs[$];

    wb_arbiter #(.FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pipe_wen   (pipe_wen),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .lu_ready   (lu_ready),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .fifo_count (fifo_count),
        .q_addr     (q_addr),
        .q_pending  (q_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic [4:0] qa,
                                input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                                input logic er, input logic [2:0] ec, input logic eq);
        vec_t v;
        v.pw = pw; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld; v.qa = qa;
        v.e_wen = ew; v.e_waddr = ea; v.e_wdata = ed;
        v.e_ready = er; v.e_count = ec; v.e_qp = eq;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic applyStimulus(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic [4:0] qa);
        pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld; q_addr = qa;
    endtask

    // Drive at the falling edge, let the rising edge take it, then sample just after.
    task automatic stepCycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic [4:0] qa);
        @(negedge clk);
        applyStimulus(pw, pa, pd, lv, la, ld, qa);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Columns: pipe(wen,addr,data) lu(valid,addr,data) q_addr | w_en w_addr w_data lu_ready count q_pending
        // Pipe priority: r3 every cycle while r5, r6 queue up, then drain in order
        vecs.push_back(mk(1,3,'h11, 1,5,'hA, 5,   1,3,'h11, 1,1,1));
        vecs.push_back(mk(1,3,'h11, 1,6,'hB, 6,   1,3,'h11, 1,2,1));
        vecs.push_back(mk(0,0,0,    0,0,0,   5,   1,5,'hA,  1,1,0));
        vecs.push_back(mk(0,0,0,    0,0,0,   6,   1,6,'hB,  1,0,0));
        vecs.push_back(mk(0,0,0,    0,0,0,   0,   0,6,'hB,  1,0,0));
        // Full queue: four accepted, fifth held until a slot frees
        vecs.push_back(mk(1,3,'h12, 1,1,'h1, 1,   1,3,'h12, 1,1,1));
        vecs.push_back(mk(1,3,'h13, 1,2,'h2, 2,   1,3,'h13, 1,2,1));
        vecs.push_back(mk(1,3,'h14, 1,4,'h4, 4,   1,3,'h14, 1,3,1));
        vecs.push_back(mk(1,3,'h15, 1,5,'h5, 5,   1,3,'h15, 0,4,1));
        vecs.push_back(mk(1,3,'h16, 1,6,'h6, 6,   1,3,'h16, 0,4,0));
        vecs.push_back(mk(0,0,0,    1,6,'h6, 6,   1,1,'h1,  1,3,0));
        vecs.push_back(mk(0,0,0,    1,6,'h6, 6,   1,2,'h2,  1,3,1));
        vecs.push_back(mk(0,0,0,    0,0,0,   6,   1,4,'h4,  1,2,1));
        vecs.push_back(mk(0,0,0,    0,0,0,   6,   1,5,'h5,  1,1,1));
        vecs.push_back(mk(0,0,0,    0,0,0,   6,   1,6,'h6,  1,0,0));
        vecs.push_back(mk(0,0,0,    0,0,0,   0,   0,6,'h6,  1,0,0));
        // WAW kill of a queued entry, then same-cycle lu/pipe collision
        vecs.push_back(mk(1,3,'h20, 1,7,'h1, 7,   1,3,'h20, 1,1,1));
        vecs.push_back(mk(1,7,'h2,  0,0,0,   7,   1,7,'h2,  1,1,0));
        vecs.push_back(mk(0,0,0,    0,0,0,   7,   0,7,'h1,  1,0,0));
        vecs.push_back(mk(1,8,'h30, 1,8,'h31, 8,  1,8,'h30, 1,0,0));
        vecs.push_back(mk(0,0,0,    0,0,0,   8,   0,8,'h30, 1,0,0));
        // Kill hits only the matching address
        vecs.push_back(mk(1,3,'h40, 1,9,'h91,  10, 1,3,'h40, 1,1,0));
        vecs.push_back(mk(1,3,'h41, 1,10,'hA1, 10, 1,3,'h41, 1,2,1));
        vecs.push_back(mk(1,9,'h42, 0,0,0,     9,  1,9,'h42, 1,2,0));
        vecs.push_back(mk(0,0,0,    0,0,0,     10, 0,9,'h91, 1,1,1));
        vecs.push_back(mk(0,0,0,    0,0,0,     10, 1,10,'hA1,1,0,0));
        // r0: lu push dropped, pipe r0 leaves slot for queued r4
        vecs.push_back(mk(0,0,0,    1,0,'hFF, 0,  0,10,'hA1,1,0,0));
        vecs.push_back(mk(1,3,'h50, 1,4,'h44, 4,  1,3,'h50, 1,1,1));
        vecs.push_back(mk(1,0,'h99, 0,0,0,    4,  1,4,'h44, 1,0,0));
        vecs.push_back(mk(0,0,0,    0,0,0,    0,  0,4,'h44, 1,0,0));

        // Reset held with random inputs
        resetn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, 5'($urandom));
            #1;
            checkOutput($sformatf("rst%0d.w_en", i), 32'(w_en), 32'd0);
            checkOutput($sformatf("rst%0d.w_addr", i), 32'(w_addr), 32'd0);
            checkOutput($sformatf("rst%0d.w_data", i), w_data, 32'd0);
            checkOutput($sformatf("rst%0d.lu_ready", i), 32'(lu_ready), 32'd0);
            checkOutput($sformatf("rst%0d.fifo_count", i), 32'(fifo_count), 32'd0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        resetn = 1'b1;
        #1;
        checkOutput("rel.lu_ready", 32'(lu_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            stepCycle(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].qa);
            checkOutput($sformatf("v%0d.w_en", i), 32'(w_en), 32'(vecs[i].e_wen));
            checkOutput($sformatf("v%0d.w_addr", i), 32'(w_addr), 32'(vecs[i].e_waddr));
            checkOutput($sformatf("v%0d.w_data", i), w_data, vecs[i].e_wdata);
            checkOutput($sformatf("v%0d.lu_ready", i), 32'(lu_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d.fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_count));
            checkOutput($sformatf("v%0d.q_pending", i), 32'(q_pending), 32'(vecs[i].e_qp));
        end

        // Reset mid-operation discards queued entries
        stepCycle(1'b1, 5'd3, 32'h60, 1'b1, 5'd11, 32'hB1, 5'd11);
        stepCycle(1'b1, 5'd3, 32'h61, 1'b1, 5'd12, 32'hC1, 5'd11);
        checkOutput("mid.count_before", 32'(fifo_count), 32'd2);
        checkOutput("mid.qp_before", 32'(q_pending), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("mid.w_en", 32'(w_en), 32'd0);
        checkOutput("mid.w_addr", 32'(w_addr), 32'd0);
        checkOutput("mid.w_data", w_data, 32'd0);
        checkOutput("mid.count", 32'(fifo_count), 32'd0);
        checkOutput("mid.lu_ready", 32'(lu_ready), 32'd0);
        checkOutput("mid.q_pending", 32'(q_pending), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid.after_w_en", 32'(w_en), 32'd0);
        checkOutput("mid.after_count", 32'(fifo_count), 32'd0);
        checkOutput("mid.after_qp", 32'(q_pending), 32'd0);

        // lu r9 into an empty queue with an idle pipe
        stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 5'd9);
`ifdef WB_PASSTHRU_EN
        checkOutput("pt.n1.w_en", 32'(w_en), 32'd1);
        checkOutput("pt.n1.w_addr", 32'(w_addr), 32'd9);
        checkOutput("pt.n1.w_data", w_data, 32'h55);
        checkOutput("pt.n1.count", 32'(fifo_count), 32'd0);
        checkOutput("pt.n1.qp", 32'(q_pending), 32'd0);
`else
        checkOutput("pt.n1.w_en", 32'(w_en), 32'd0);
        checkOutput("pt.n1.count", 32'(fifo_count), 32'd1);
        checkOutput("pt.n1.qp", 32'(q_pending), 32'd1);
`endif
        stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
`ifdef WB_PASSTHRU_EN
        checkOutput("pt.n2.w_en", 32'(w_en), 32'd0);
`else
        checkOutput("pt.n2.w_en", 32'(w_en), 32'd1);
`endif
        checkOutput("pt.n2.w_addr", 32'(w_addr), 32'd9);
        checkOutput("pt.n2.w_data", w_data, 32'h55);
        checkOutput("pt.n2.count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Producer side of the register-file write port: merges writebacks from the main pipeline and one long-latency unit (mul/div/load-miss) into the single `w_en`/`w_addr`/`w_data` port.
- Main-pipeline writes have absolute priority.
- Long-latency results are buffered in a small FIFO and drained in idle write slots.
- A pending-register query lets issue logic stall on registers with queued writes.

Parameters:
- FIFO_DEPTH, 4, long-latency result queue entries (power of 2, >=2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- pipe_wen  in  1  main-pipeline writeback valid (no backpressure)
- pipe_waddr  in  ADDR_W  main-pipeline destination register
- pipe_wdata  in  DATA_W  main-pipeline result
- lu_valid  in  1  long-latency result valid
- lu_waddr  in  ADDR_W  long-latency destination register
- lu_wdata  in  DATA_W  long-latency result
- lu_ready  out  1  queue can accept; transfer when lu_valid && lu_ready
- w_en  out  1  register-file write enable (registered)
- w_addr  out  ADDR_W  register-file write address (registered)
- w_data  out  DATA_W  register-file write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued, killed ones included
- q_addr  in  ADDR_W  hazard query register
- q_pending  out  1  some live queued entry targets q_addr (combinational)

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values:
  - w_en=0, w_addr=0, w_data=0.
  - FIFO empty, fifo_count=0, all entry live bits 0.
  - lu_ready=0 while resetn low.
- Reset mid-operation discards all queued entries; no partial write is emitted.
- lu_ready: lu_ready = !full, combinational from FIFO state. No push-through when full.
- Slot selection each cycle; outputs register at the next edge, so w_* reflect the decision one cycle later:
  1. Pipe write: pipe_wen && pipe_waddr!=0 selects the pipe write.
  2. FIFO head: otherwise, if FIFO non-empty, pop the head. w_en=live bit of head; w_addr/w_data from head.
  3. Idle: otherwise w_en=0; w_addr/w_data hold their previous value.
- Register 0:
  - pipe write to r0 counts as no write; the slot is free for the FIFO.
  - lu transfer to r0 is accepted (handshake completes) but not enqueued.
- Ordering rule: pipe writes are always younger in program order than any queued or same-cycle lu result.
  - On a pipe write to X, every queued entry with address X has its live bit cleared in that cycle.
  - A same-cycle lu transfer to X is accepted and dropped.
  - Killed entries still occupy the FIFO; popping one produces w_en=0 for that slot.
- Simultaneous push and pop allowed when not full; fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH; a count-based full/empty scheme distinguishes wrap.
- q_pending: 1 iff q_addr!=0 and some entry is both occupied and live with address q_addr.
  - Excludes the entry in the output register; the register file's same-cycle write bypass covers that case.
  - Same-cycle incoming lu data is not visible.
- Latency:
  - pipe write at edge N -> w_en at N+1.
  - lu transfer at N, empty FIFO, no pipe write at N+1 -> w_en at N+2.

Optional Feature:
- Macro `WB_PASSTHRU_EN`.
- Defined: if the FIFO is empty, the slot is free (no pipe write) and lu_valid && lu_waddr!=0, the lu result goes straight to the output register without being enqueued. lu latency is then 1 cycle; fifo_count stays 0.
- Undefined: every lu result passes through the FIFO; minimum lu latency 2 cycles.
- Pipe priority, kill rules and q_pending are identical in both builds.

Test Plan:
- Reset: hold resetn=0 with random inputs -> w_en=0, w_addr=0, w_data=0, lu_ready=0, fifo_count=0. Release -> lu_ready=1.
- Pipe priority: pipe write r3=0x11 every cycle while lu pushes r5=0xA, r6=0xB.
  - r3 written each cycle; fifo_count reaches 2.
  - After pipe_wen drops: r5=0xA, then r6=0xB on consecutive cycles.
- Full FIFO: continuous pipe writes, lu pushes 5 results.
  - lu_ready=0 after 4 accepted; fifo_count=4; 5th held until first pop.
- WAW kill:
  - Queue r7=0x1; then pipe write r7=0x2 -> queued r7 killed, q_pending(r7)=0. Drain gives w_en=0 slot; final r7=0x2.
  - Same-cycle lu r8 and pipe r8 -> only pipe value written.
- r0 handling: lu push r0=0xFF -> handshake completes, fifo_count stays 0. Pipe write r0 plus queued r4 -> r4 drained in that slot.
- Passthru (`WB_PASSTHRU_EN` on): idle pipe, lu r9=0x55 at edge N -> w_en=1, w_addr=9, w_data=0x55 at N+1, fifo_count=0.
  - Without the macro: the same write appears at N+2.
